median_axis_tx: RTL and testbench

MEDIAN_AXIS_TX -- requirements
Module: median_axis_tx

---
 rtl/median_axis_tx.sv | 158 +++++++++++++++
 tb/tb_median_axis_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_axis_tx.sv
// -----------------------------------------------------------------------------
// median_axis_tx
//
// Output stage for a median filter. Results leaving the upstream sorting
// network are written into a first-word-fall-through FIFO and presented on an
// AXI4-Stream master port. Issue credit is handed to the upstream so that the
// beats already inside the sorter always have room in the FIFO when they
// arrive.
//
// Optional feature (compile-time macro MEDIAN_TX_FRAME_CNT_EN):
//   adds o_frame_cnt, a 16-bit count of accepted start-of-frame beats.
//
// Parameters
//   DATA_WIDTH    pixel width in bits
//   PIPE_LATENCY  max cycles a beat spends in the upstream sorting network
//   FIFO_DEPTH    output buffer entries (power of 2, >= PIPE_LATENCY+2)
//
// Ports
//   i_clk          clock, rising edge
//   i_aresetn      asynchronous active-low reset
//   i_issue        a beat entered the sorter pipeline this cycle
//   o_issue_ok     upstream may issue a beat this cycle
//   i_pix_valid    median result present at the pipeline output
//   i_pix_data     median pixel value
//   i_pix_user     start-of-frame tag travelling with the data
//   i_pix_last     end-of-line tag travelling with the data
//   m_axis_*       AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   o_overflow     sticky: a result or an issue arrived with no room
//   o_frame_cnt    (MEDIAN_TX_FRAME_CNT_EN only) accepted tuser=1 beats
// -----------------------------------------------------------------------------
module median_axis_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int PIPE_LATENCY = 9,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic                  i_issue,
    output logic                  o_issue_ok,
    input  logic                  i_pix_valid,
    input  logic [DATA_WIDTH-1:0] i_pix_data,
    input  logic                  i_pix_user,
    input  logic                  i_pix_last,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
`ifdef MEDIAN_TX_FRAME_CNT_EN
    output logic [15:0]           o_frame_cnt,
`endif
    output logic                  o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;            // wide enough to hold FIFO_DEPTH
    localparam int EW = DATA_WIDTH + 2;    // {user, last, data}

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] in_flight;
    logic [CW:0]   credit_used;
    logic [EW-1:0] head;

    logic full;
    logic push;
    logic pop;
    logic drop;
    logic issue_err;

    // -------------------------------------------------------------------------
    // Control decode (all from registered state plus current inputs)
    // -------------------------------------------------------------------------
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = m_axis_tvalid && m_axis_tready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = i_pix_valid && (!full || pop);
    assign drop      = i_pix_valid && full && !pop;
    assign issue_err = i_issue && !o_issue_ok;

    assign credit_used = {1'b0, count} + {1'b0, in_flight};
    assign o_issue_ok  = (credit_used < (CW + 1)'(FIFO_DEPTH));

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the data array has no reset on purpose; validity is carried by
    // count alone, and the outputs below are masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_pix_user, i_pix_last, i_pix_data};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // In-flight tracking: beats issued into the sorter but not yet returned.
    // Saturates at both ends so a misbehaving upstream cannot wrap it.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            in_flight <= '0;
        end else if (i_issue && !i_pix_valid) begin
            if (in_flight != {CW{1'b1}}) in_flight <= in_flight + CW'(1);
        end else if (i_pix_valid && !i_issue) begin
            if (in_flight != '0) in_flight <= in_flight - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_overflow <= 1'b0;
        end else if (drop || issue_err) begin
            o_overflow <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output: head entry, forced to zero while empty so stale memory never
    // leaks out (including after a mid-stream reset).
    // -------------------------------------------------------------------------
    assign m_axis_tvalid = (count != '0);
    assign head          = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign m_axis_tuser  = head[EW-1];
    assign m_axis_tlast  = head[EW-2];
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];

`ifdef MEDIAN_TX_FRAME_CNT_EN
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_frame_cnt <= '0;
        end else if (pop && m_axis_tuser) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_median_axis_tx.sv
`timescale 1ns/1ps
module tb_median_axis_tx;

    logic       i_clk = 1'b0;
    logic       i_aresetn;
    logic       i_issue;
    logic       o_issue_ok;
    logic       i_pix_valid;
    logic [7:0] i_pix_data;
    logic       i_pix_user;
    logic       i_pix_last;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tuser;
    logic       m_axis_tlast;
    logic       o_overflow;
`ifdef MEDIAN_TX_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    median_axis_tx #(
        .DATA_WIDTH  (8),
        .PIPE_LATENCY(9),
        .FIFO_DEPTH  (16)
    ) dut (
        .i_clk        (i_clk),
        .i_aresetn    (i_aresetn),
        .i_issue      (i_issue),
        .o_issue_ok   (o_issue_ok),
        .i_pix_valid  (i_pix_valid),
        .i_pix_data   (i_pix_data),
        .i_pix_user   (i_pix_user),
        .i_pix_last   (i_pix_last),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
`ifdef MEDIAN_TX_FRAME_CNT_EN
        .o_frame_cnt  (o_frame_cnt),
`endif
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_issue     = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = 8'h00;
        i_pix_user  = 1'b0;
        i_pix_last  = 1'b0;
    endtask

    initial begin
        logic [1:0] pv;
        logic [7:0] pd [2];
        int issued;

        idle_inputs();
        m_axis_tready = 1'b0;
        i_aresetn     = 1'b0;
        tick();
        tick();

        // ---- reset state -----------------------------------------------
        check("rst_tvalid",   m_axis_tvalid, 0);
        check("rst_tdata",    m_axis_tdata,  0);
        check("rst_tuser",    m_axis_tuser,  0);
        check("rst_tlast",    m_axis_tlast,  0);
        check("rst_overflow", o_overflow,    0);
        i_aresetn = 1'b1;
        tick();
        check("rst_issue_ok", o_issue_ok, 1);
        check("rst_tvalid2",  m_axis_tvalid, 0);

        // ---- pass-through: 0x11,0x22,0x33 back to back, tready=1 --------
        m_axis_tready = 1'b1;
        i_issue = 1'b1; i_pix_valid = 1'b1; i_pix_data = 8'h11;
        tick();
        check("pt_v0", m_axis_tvalid, 1);
        check("pt_d0", m_axis_tdata,  8'h11);
        i_pix_data = 8'h22;
        tick();
        check("pt_v1", m_axis_tvalid, 1);
        check("pt_d1", m_axis_tdata,  8'h22);
        i_pix_data = 8'h33;
        tick();
        check("pt_v2", m_axis_tvalid, 1);
        check("pt_d2", m_axis_tdata,  8'h33);
        idle_inputs();
        tick();
        check("pt_done", m_axis_tvalid, 0);

        // ---- backpressure: 2-cycle sorter, issue while o_issue_ok --------
        m_axis_tready = 1'b0;
        pv = 2'b00;
        pd[0] = 8'h00;
        pd[1] = 8'h00;
        issued = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_issue     = o_issue_ok;
            i_pix_valid = pv[1];
            i_pix_data  = pd[1];
            pv[1] = pv[0];
            pd[1] = pd[0];
            pv[0] = i_issue;
            pd[0] = 8'h40 + 8'(issued);
            if (i_issue) issued++;
            tick();
        end
        idle_inputs();
        check("bp_issued",   issued,        16);
        check("bp_issue_ok", o_issue_ok,    0);
        check("bp_tvalid",   m_axis_tvalid, 1);
        check("bp_head",     m_axis_tdata,  8'h40);
        check("bp_ovf",      o_overflow,    0);

        // ---- full with simultaneous push and pop ------------------------
        m_axis_tready = 1'b1;
        i_pix_valid   = 1'b1;
        i_pix_data    = 8'h77;
        tick();
        idle_inputs();
        m_axis_tready = 1'b0;
        check("fpp_issue_ok", o_issue_ok,   0);
        check("fpp_ovf",      o_overflow,   0);
        check("fpp_head",     m_axis_tdata, 8'h41);
        tick();
        check("fpp_hold",     m_axis_tdata, 8'h41);

        // drain: 0x41..0x4F then 0x77
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_v", m_axis_tvalid, 1);
            check("drain_d", m_axis_tdata, (i < 15) ? 8'h41 + 8'(i) : 8'h77);
            tick();
        end
        check("drain_empty", m_axis_tvalid, 0);
        check("drain_ok",    o_issue_ok,    1);

        // ---- overflow: fill 16, push 0xAA with tready=0 -----------------
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_issue = 1'b1; i_pix_valid = 1'b1; i_pix_data = 8'h80 + 8'(i);
            tick();
        end
        check("ovf_pre", o_overflow, 0);
        i_issue = 1'b0; i_pix_valid = 1'b1; i_pix_data = 8'hAA;
        tick();
        idle_inputs();
        check("ovf_set", o_overflow, 1);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_d", m_axis_tdata, 8'h80 + 8'(i));
            tick();
        end
        check("ovf_no_aa", m_axis_tvalid, 0);
        tick();
        check("ovf_sticky", o_overflow, 1);

        // ---- mid-stream reset with 5 buffered and 2 in flight -----------
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_issue = 1'b1; i_pix_valid = 1'b1; i_pix_data = 8'hC0 + 8'(i);
            tick();
        end
        i_pix_valid = 1'b0;
        tick();
        tick();
        idle_inputs();
        check("mr_buffered", m_axis_tvalid, 1);
        i_aresetn = 1'b0;
        #1;
        check("mr_tvalid_async", m_axis_tvalid, 0);
        check("mr_tdata_async",  m_axis_tdata,  0);
        tick();
        i_aresetn = 1'b1;
        tick();
        check("mr_issue_ok", o_issue_ok,    1);
        check("mr_ovf",      o_overflow,    0);
        m_axis_tready = 1'b1;
        tick();
        check("mr_no_emit",  m_axis_tvalid, 0);

        // ---- sideband alignment -----------------------------------------
        m_axis_tready = 1'b0;
        i_issue = 1'b1; i_pix_valid = 1'b1; i_pix_data = 8'h5A; i_pix_user = 1'b1;
        tick();
        i_pix_data = 8'h5B; i_pix_user = 1'b0; i_pix_last = 1'b1;
        tick();
        idle_inputs();
        check("sb_d0", m_axis_tdata, 8'h5A);
        check("sb_u0", m_axis_tuser, 1);
        check("sb_l0", m_axis_tlast, 0);
`ifdef MEDIAN_TX_FRAME_CNT_EN
        check("sb_fc0", o_frame_cnt, 0);
`endif
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check("sb_d1", m_axis_tdata, 8'h5B);
        check("sb_u1", m_axis_tuser, 0);
        check("sb_l1", m_axis_tlast, 1);
`ifdef MEDIAN_TX_FRAME_CNT_EN
        check("sb_fc1", o_frame_cnt, 1);
`endif
        m_axis_tready = 1'b1;
        tick();
        check("sb_empty", m_axis_tvalid, 0);
        check("sb_tlast0", m_axis_tlast, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
